// File: rtl/video_pkg.sv
// Shared video timing constants and the fetch-arbiter state encoding.
package video_pkg;
  typedef enum logic [1:0] {IDLE, VID, CPU} state_t;

  localparam int unsigned HACTIVE_DEF    = 640;
  localparam int unsigned VACTIVE_DEF    = 231;
  localparam int unsigned LINE_WORDS_DEF = 80;
  localparam int unsigned PPF_DEF        = 8;
  localparam int unsigned PPF_LOG2       = $clog2(PPF_DEF);
  localparam logic [15:0] VID_BASE_DEF   = 16'h2000;
endpackage

// File: rtl/video_fetch_tick_gen.sv
// Derives display fetch ticks, word index, line base address and the CPU guard
// window from the raster counters.
module video_fetch_tick_gen
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned HACTIVE    = HACTIVE_DEF,
  parameter int unsigned VACTIVE    = VACTIVE_DEF,
  parameter int unsigned PPF        = PPF_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned CPU_GUARD  = 3,
  parameter logic [ADDR_W-1:0] VID_BASE = ADDR_W'(VID_BASE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [10:0]       hpos,
  input  logic [9:0]        vpos,
  output logic              tick,
  output logic [6:0]        word,
  output logic [ADDR_W-1:0] line_base,
  output logic              guard
);
  localparam int unsigned      PLOG   = $clog2(PPF);
  localparam logic [10:0]      HACT   = 11'(HACTIVE);
  localparam logic [10:0]      HLAST  = 11'(HACTIVE - 1);
  localparam logic [10:0]      HGUARD = 11'(HACTIVE - CPU_GUARD);
  localparam logic [9:0]       VACT   = 10'(VACTIVE);
  localparam logic [PLOG-1:0]  GSTART = PLOG'(PPF - CPU_GUARD);
  localparam logic [ADDR_W-1:0] LW    = ADDR_W'(LINE_WORDS);

  logic            active;
  logic [PLOG-1:0] phase;

  assign active = (vpos < VACT) && (hpos < HACT);
  assign phase  = hpos[PLOG-1:0];
  assign tick   = ce_pix && active && (phase == '0);
  assign word   = 7'(hpos >> PLOG);
  // The last word of the line is guarded too, even if HACTIVE is not PPF-aligned.
  assign guard  = active && ((phase >= GSTART) || (hpos >= HGUARD));

  always_ff @(posedge clk) begin
    if (reset) begin
      line_base <= VID_BASE;
    end else if (ce_pix) begin
      if (vpos >= VACT) begin
        line_base <= VID_BASE;
      end else if (hpos == HLAST) begin
        line_base <= line_base + LW;
      end
    end
  end
endmodule

// File: rtl/video_fetch_scheduler.sv
// Arbitrates the single video-RAM port between raster-scheduled display fetches
// (always preferred) and a CPU/DMA requester served in free slots and blanking.
module video_fetch_scheduler
  import video_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned HACTIVE    = HACTIVE_DEF,
  parameter int unsigned VACTIVE    = VACTIVE_DEF,
  parameter int unsigned PPF        = PPF_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned CPU_GUARD  = 3,
  parameter logic [ADDR_W-1:0] VID_BASE = ADDR_W'(VID_BASE_DEF)
) (
  input  logic              clk_vid,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [10:0]       hpos,
  input  logic [9:0]        vpos,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  output logic [6:0]        vid_word,
  output logic              vid_underrun
);
  logic              tick;
  logic              guard;
  logic [6:0]        tick_word;
  logic [ADDR_W-1:0] line_base;

  video_fetch_tick_gen #(
    .ADDR_W     (ADDR_W),
    .HACTIVE    (HACTIVE),
    .VACTIVE    (VACTIVE),
    .PPF        (PPF),
    .LINE_WORDS (LINE_WORDS),
    .CPU_GUARD  (CPU_GUARD),
    .VID_BASE   (VID_BASE)
  ) u_tick_gen (
    .clk       (clk_vid),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .hpos      (hpos),
    .vpos      (vpos),
    .tick      (tick),
    .word      (tick_word),
    .line_base (line_base),
    .guard     (guard)
  );

  state_t            state, next_state;
  logic              take_vid, take_cpu;
  logic              pend_valid;
  logic [6:0]        pend_word;
  logic [ADDR_W-1:0] pend_addr;
  logic [6:0]        cur_word;

  always_ff @(posedge clk_vid) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A tick in the same cycle also blocks a CPU start so display keeps priority.
  always_comb begin
    next_state = state;
    take_vid   = 1'b0;
    take_cpu   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_valid) begin
          next_state = VID;
          take_vid   = 1'b1;
        end else if (cpu_req && !guard && !tick) begin
          next_state = CPU;
          take_cpu   = 1'b1;
        end
      end
      VID, CPU: if (mem_ack) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      pend_valid   <= 1'b0;
      pend_word    <= '0;
      pend_addr    <= '0;
      vid_underrun <= 1'b0;
    end else if (tick) begin
      pend_valid <= 1'b1;
      pend_word  <= tick_word;
      pend_addr  <= line_base + ADDR_W'(tick_word);
      if (pend_valid && !take_vid) vid_underrun <= 1'b1;
    end else if (take_vid) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cur_word  <= '0;
    end else if (take_vid) begin
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= pend_addr;
      cur_word <= pend_word;
    end else if (take_cpu) begin
      mem_req   <= 1'b1;
      mem_we    <= cpu_we;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
    end else if (mem_ack && state != IDLE) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
      vid_word  <= '0;
    end else begin
      cpu_ack   <= (state == CPU) && mem_ack;
      vid_valid <= (state == VID) && mem_ack;
      if ((state == CPU) && mem_ack) cpu_rdata <= mem_rdata;
      if ((state == VID) && mem_ack) begin
        vid_data <= mem_rdata;
        vid_word <= cur_word;
      end
    end
  end
endmodule

// File: tb/tb_video_fetch_scheduler.sv
// Scoreboard bench: raster stimulus, a latency-programmable memory model and a
// level-request CPU driver; display and CPU completions are checked in order.
module tb_video_fetch_scheduler;
  localparam logic [15:0] KEY = 16'h5A3C;

  logic        clk_vid = 1'b0;
  logic        reset, ce_pix;
  logic [10:0] hpos;
  logic [9:0]  vpos;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        vid_valid, vid_underrun;
  logic [15:0] vid_data;
  logic [6:0]  vid_word;

  video_fetch_scheduler #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .hpos(hpos), .vpos(vpos),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .vid_valid(vid_valid), .vid_data(vid_data), .vid_word(vid_word),
    .vid_underrun(vid_underrun)
  );

  always #5 clk_vid = ~clk_vid;

  typedef struct { logic [6:0] word; logic [15:0] data; } vid_exp_t;
  typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } cpu_cmd_t;
  typedef struct { logic [15:0] addr; logic we; int unsigned start; int unsigned ackc; } acc_t;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  vid_exp_t    vid_q[$];
  cpu_cmd_t    cpu_exp_q[$];
  cpu_cmd_t    cpu_cmd_q[$];
  acc_t        acc_log[$];
  logic [15:0] store [logic [15:0]];
  logic        hold = 1'b0, force_ack = 1'b0, cpu_flush = 1'b0, drop_tick = 1'b0;
  int unsigned last_ack_cyc = 0;
  int unsigned vid_seen = 0, cpu_ack_seen = 0;

  always @(posedge clk_vid) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return store.exists(a) ? store[a] : (a ^ KEY);
  endfunction

  // Memory model: acks mem_lat cycles after mem_req first appears, unless held.
  int unsigned mem_lat = 2;
  initial begin
    int unsigned lat_cnt = 0;
    int unsigned cur_start = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk_vid); #1;
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        last_ack_cyc = cyc;
      end else if (!mem_req) begin
        lat_cnt = 0;
      end else begin
        if (lat_cnt == 0) cur_start = cyc;
        lat_cnt++;
        if (lat_cnt > mem_lat && !hold) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? 16'h0000 : mem_read(mem_addr);
          if (mem_we) store[mem_addr] = mem_wdata;
          acc_log.push_back('{mem_addr, mem_we, cur_start, cyc});
          last_ack_cyc = cyc;
          lat_cnt = 0;
        end
      end
    end
  end

  // CPU requester: holds cpu_req until the cpu_ack cycle, then presents the next command.
  initial begin
    cpu_cmd_t c;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    forever begin
      @(posedge clk_vid); #1;
      if (cpu_flush) begin
        cpu_req = 1'b0;
        cpu_cmd_q.delete();
      end else begin
        if (cpu_req && cpu_ack) cpu_req = 1'b0;
        if (!cpu_req && cpu_cmd_q.size() > 0) begin
          c = cpu_cmd_q.pop_front();
          cpu_req = 1'b1; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.data;
        end
      end
    end
  end

  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [32:0] prev_bus = '0;
  always @(negedge clk_vid) begin
    vid_exp_t ve;
    cpu_cmd_t ce;
    if (vid_valid) begin
      vid_seen <= vid_seen + 1;
      check("vid_latency", 64'(cyc), 64'(last_ack_cyc + 1));
      if (vid_q.size() == 0) check("vid_unexpected", vid_valid, 1'b0);
      else begin
        ve = vid_q.pop_front();
        check("vid_word", vid_word, ve.word);
        check("vid_data", vid_data, ve.data);
      end
    end
    if (cpu_ack) begin
      cpu_ack_seen <= cpu_ack_seen + 1;
      check("cpu_ack_latency", 64'(cyc), 64'(last_ack_cyc + 1));
      if (cpu_exp_q.size() == 0) check("cpu_ack_unexpected", cpu_ack, 1'b0);
      else begin
        ce = cpu_exp_q.pop_front();
        if (!ce.we) check("cpu_rdata", cpu_rdata, ce.data);
      end
    end
    if (mem_req && prev_req && !prev_ack) check("mem_hold", {mem_addr, mem_we, mem_wdata}, prev_bus);
    if (prev_ack) check("mem_req_drop", mem_req, 1'b0);
    if (mem_req && mem_addr >= 16'h2000) check("vid_we", mem_we, 1'b0);
    prev_req <= mem_req;
    prev_ack <= mem_ack;
    prev_bus <= {mem_addr, mem_we, mem_wdata};
  end

  task automatic step(input int h, input int v);
    vid_exp_t e;
    hpos = 11'(h); vpos = 10'(v); ce_pix = 1'b1;
    if (v < 231 && h < 640 && (h % 8) == 0 && !drop_tick) begin
      e.word = 7'(h / 8);
      e.data = mem_read(16'(32'h2000 + v * 80 + h / 8));
      vid_q.push_back(e);
    end
    @(posedge clk_vid); #1;
  endtask

  task automatic push_cpu(input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_cmd_t c;
    c.we = we; c.addr = a; c.data = we ? d : mem_read(a);
    cpu_exp_q.push_back(c);
    c.data = d;
    cpu_cmd_q.push_back(c);
  endtask

  initial begin
    int unsigned rd_start, w1_ack, n_before, n_ack, n;
    int unsigned wst[$];
    int unsigned wack[$];
    reset = 1'b1; ce_pix = 1'b0; hpos = '0; vpos = '0;
    repeat (3) @(posedge clk_vid);
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 16'h0);
    check("rst_vid_valid", vid_valid, 1'b0);
    check("rst_vid_data", vid_data, 16'h0);
    check("rst_vid_word", vid_word, 7'h0);
    check("rst_underrun", vid_underrun, 1'b0);
    reset = 1'b0;

    for (int h = 0; h < 800; h++) step(h, 0);
    check("line0_words", 64'(vid_seen), 64'd80);
    check("line0_underrun", vid_underrun, 1'b0);

    for (int h = 0; h < 800; h++) begin
      if (h == 5) push_cpu(1'b0, 16'h0123, 16'h0);
      if (h == 700)
        for (int i = 0; i < 4; i++) push_cpu(1'b1, 16'(16'h0200 + i), 16'(16'hC000 + i * 16'h0111));
      step(h, 1);
    end
    rd_start = 0; w1_ack = 0;
    foreach (acc_log[i]) begin
      if (acc_log[i].addr == 16'h0123) rd_start = acc_log[i].start;
      if (acc_log[i].addr == 16'h2051) w1_ack = acc_log[i].ackc;
      if (acc_log[i].we && acc_log[i].addr[15:8] == 8'h02) begin
        wst.push_back(acc_log[i].start);
        wack.push_back(acc_log[i].ackc);
      end
    end
    check("cpu_after_vid1", rd_start > w1_ack, 1'b1);
    check("hblank_writes", 64'(wst.size()), 64'd4);
    if (wst.size() == 4)
      for (int i = 1; i < 4; i++) check("hblank_gap", 64'(wst[i]), 64'(wack[i-1] + 2));
    for (int i = 0; i < 4; i++)
      check("hblank_wdata", mem_read(16'(16'h0200 + i)), 16'(16'hC000 + i * 16'h0111));
    check("cpu_acks_line1", 64'(cpu_ack_seen), 64'd5);

    for (int v = 2; v < 230; v++) step(639, v);

    for (int h = 0; h < 800; h++) begin
      if (h == 96) hold = 1'b1;
      if (h == 117) hold = 1'b0;
      drop_tick = (h == 104);
      step(h, 230);
      drop_tick = 1'b0;
      if (h == 108) check("underrun_before", vid_underrun, 1'b0);
      if (h == 120) check("underrun_set", vid_underrun, 1'b1);
    end
    check("underrun_sticky", vid_underrun, 1'b1);

    n_before = acc_log.size();
    for (int h = 0; h < 800; h++) step(h, 231);
    check("vblank_no_fetch", 64'(acc_log.size()), 64'(n_before));

    n_before = acc_log.size();
    for (int h = 0; h < 800; h++) step(h, 0);
    if (acc_log.size() > n_before) check("wrap_addr", acc_log[n_before].addr, 16'h2000);
    else check("wrap_fetch_seen", 64'(acc_log.size()), 64'(n_before + 1));
    check("underrun_still", vid_underrun, 1'b1);

    hold = 1'b1;
    push_cpu(1'b0, 16'h0300, 16'h0);
    n = 0;
    while (!mem_req && n < 20) begin step(700, 231); n++; end
    check("rst_req_up", mem_req, 1'b1);
    n_ack = cpu_ack_seen;
    reset = 1'b1; cpu_flush = 1'b1;
    cpu_exp_q.delete();
    step(700, 231);
    check("midrst_mem_req", mem_req, 1'b0);
    reset = 1'b0;
    step(700, 231);
    hold = 1'b0;
    step(700, 231);
    cpu_flush = 1'b0;
    #1; force_ack = 1'b1;
    step(700, 231);
    #1; force_ack = 1'b0;
    repeat (4) step(700, 231);
    check("late_ack_no_req", mem_req, 1'b0);
    check("late_ack_no_cpu_ack", 64'(cpu_ack_seen), 64'(n_ack));
    check("rst_underrun_clr", vid_underrun, 1'b0);
    check("vid_q_drained", 64'(vid_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
